tracker_record_sampler: RTL and testbench
=========================================

Name: tracker_record_sampler

Overview:
- Next-generation NoC message tracker: snoops a valid/ready NoC link as a zero-latency pass-through and logs one record per selected message.
- Each record holds packet_id, msg_len, start/end timestamp and duration.
- Adds over the previous tracker:
  - parametrised timestamp and counter widths;
  - packet-id mask filtering;
  - 1-in-2^N sampling;
  - a 1-entry log buffer with drop accounting, so the NoC is never back-pressured by logging.
- Sits inline between a NoC router port and a tile; records feed the tracker log memory.

Parameters:
- DATA_NOC_W, 512, NoC flit width; header layout is beehive_noc_hdr_flit.
- TS_W, 64, free-running timestamp width.
- CNT_W, 32, width of the rec_cnt and drop_cnt statistics counters.
- SAMPLE_SHIFT_W, 4, width of cfg_sample_shift.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- noc_in_val  in  1  upstream flit valid
- noc_in_data  in  DATA_NOC_W  upstream flit
- noc_in_rdy  out  1  = noc_out_rdy
- noc_out_val  out  1  = noc_in_val
- noc_out_data  out  DATA_NOC_W  = noc_in_data
- noc_out_rdy  in  1  downstream ready
- cfg_en  in  1  tracking enable
- cfg_filter_id  in  PACKET_ID_W  packet-id match value
- cfg_filter_mask  in  PACKET_ID_W  1 = bit compared
- cfg_sample_shift  in  SAMPLE_SHIFT_W  record 1 of every 2^shift matched messages
- log_wr_req_val  out  1  record valid
- log_wr_req_data  out  tracker_rec_struct  record
- log_wr_req_rdy  in  1  log sink accepts
- rec_cnt  out  CNT_W  records emitted (saturating)
- drop_cnt  out  CNT_W  records lost to a full buffer (saturating)

Behaviour:
- Pass-through:
  - purely combinational, zero latency; tracking never alters or stalls the NoC.
  - beat = noc_in_val && noc_out_rdy.
- Timestamp: ts_reg increments every cycle, wraps modulo 2^TS_W.
- Message framing:
  - msg_len (header field) = number of body flits after the header.
  - msg_len = 0 means a header-only message.
- FSM, two states:
  - HDR (reset state): on a beat:
    - latch packet_id, msg_len, start_ts = ts_reg, and sel = the selection result below;
    - clear flit_cnt;
    - msg_len == 0 -> message complete this cycle, stay HDR;
    - otherwise go to BODY.
  - BODY: each beat increments flit_cnt (width MSG_LENGTH_WIDTH). The beat where flit_cnt+1 == msg_len completes the message and returns to HDR.
  - No beat -> no state change.
- Selection, evaluated on the header beat only:
  - match = cfg_en && ((hdr.packet_id ^ cfg_filter_id) & cfg_filter_mask) == 0.
  - sample_cnt (SAMPLE_SHIFT_W+1 bits wide) increments on every matched header.
  - sel = match && (sample_cnt & ((1<<cfg_sample_shift)-1)) == 0.
  - shift = 0 selects every matched message.
  - cfg inputs are sampled only at header beats; mid-message changes affect the next message only.
- Completion of a selected message builds the record:
  - {packet_id, msg_len, start_ts, end_ts = ts_reg on the completing beat, duration = end_ts - start_ts modulo 2^TS_W}.
  - A header-only message has duration 0.
- Log buffer (1 entry, registered outputs):
  - completion with slot empty, or with log_wr_req_val && log_wr_req_rdy in the same cycle -> slot loads; log_wr_req_val = 1 on the next cycle; rec_cnt++.
  - completion while slot full and not draining -> record discarded, drop_cnt++, slot unchanged.
  - val is held with data stable until rdy; sink handshake is standard valid/ready.
- Counters saturate at all-ones; they never wrap.
- Reset (asynchronous, any time including mid-message):
  - FSM -> HDR; flit_cnt, sample_cnt, ts_reg, rec_cnt, drop_cnt -> 0; log_wr_req_val -> 0; slot contents don't-care.
  - The first beat after reset is treated as a header; upstream is reset with this block.

Decomposition:
- tracker_pkg additions:
  - tracker_rec_struct, packed {packet_id, msg_len, start_ts[TS_W], end_ts[TS_W], duration[TS_W]}; TS_W default 64 taken from package constant TRACKER_TS_W;
  - tracker_rec_state_e {HDR, BODY}.
- Header cast and PACKET_ID_W/MSG_LENGTH_WIDTH come from beehive_noc_msg.
- One natural sub-module: tracker_rec_slot, the 1-entry valid/ready buffer with drop and record counters.
- The FSM, filter and sampler stay in the top module.

Test Plan:
- cfg_en=1, mask=0, shift=0; send header with packet_id=5, msg_len=3 plus 3 body flits on back-to-back beats starting at ts=10 -> one record {5, 3, start 10, end 13, duration 3}; rec_cnt=1; NoC output identical to input every cycle.
- Header-only message (msg_len=0) at ts=20 -> record start=end=20, duration 0; FSM stays HDR; a following header on the next cycle is tracked correctly.
- filter_id=0x4, mask=0xC; send packet_ids 0x4, 0x8, 0x7 -> records only for 0x4 and 0x7; rec_cnt=2.
- shift=2; send 8 matched messages -> records only for the 1st and 5th.
- log_wr_req_rdy=0; complete 3 selected messages -> first held in slot, drop_cnt=2. Raise rdy on the cycle a 4th completes -> slot hands off the first and loads the fourth; drop_cnt stays 2.
- Downstream stall (noc_out_rdy=0 for 5 cycles mid-BODY) -> flit_cnt frozen, end_ts taken at the real last beat. Assert rst mid-BODY -> log val=0, counters=0; the next flit is parsed as a header.

Source files
------------

// File: rtl/tracker_record_sampler_pkg.sv
// Shared types for the NoC message tracker: NoC header layout, log record format,
// framing FSM states and a small mask helper used by the sampler.
package tracker_record_sampler_pkg;

    // Header field widths follow the beehive_noc_msg definitions.
    localparam int PACKET_ID_W      = 16;
    localparam int MSG_LENGTH_WIDTH = 8;
    localparam int MSG_TYPE_W       = 8;
    localparam int XY_W             = 8;
    localparam int TRACKER_TS_W     = 64;

    typedef struct packed {
        logic [XY_W-1:0]             dst_x;
        logic [XY_W-1:0]             dst_y;
        logic [MSG_LENGTH_WIDTH-1:0] msg_len;
        logic [MSG_TYPE_W-1:0]       msg_type;
        logic [PACKET_ID_W-1:0]      packet_id;
    } beehive_noc_hdr_flit;

    // The header sits in the most-significant bits of a flit; offsets count from its LSB.
    localparam int NOC_HDR_W       = $bits(beehive_noc_hdr_flit);
    localparam int HDR_PKT_ID_LSB  = 0;
    localparam int HDR_MSG_LEN_LSB = PACKET_ID_W + MSG_TYPE_W;

    typedef struct packed {
        logic [PACKET_ID_W-1:0]      packet_id;
        logic [MSG_LENGTH_WIDTH-1:0] msg_len;
        logic [TRACKER_TS_W-1:0]     start_ts;
        logic [TRACKER_TS_W-1:0]     end_ts;
        logic [TRACKER_TS_W-1:0]     duration;
    } tracker_rec_struct;

    typedef enum logic {
        HDR,
        BODY
    } tracker_rec_state_e;

    function automatic logic [31:0] low_ones(input logic [31:0] n);
        return (n >= 32'd32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    endfunction

endpackage

// File: rtl/tracker_record_sampler_if.sv
// NoC link (upstream and downstream halves) plus the log write port of the tracker.
// The master modport is the tracker's view; slave is the surrounding fabric/log side.
interface tracker_record_sampler_if #(
    parameter int DATA_NOC_W = 512
) ();
    import tracker_record_sampler_pkg::*;

    logic                  noc_in_val;
    logic [DATA_NOC_W-1:0] noc_in_data;
    logic                  noc_in_rdy;
    logic                  noc_out_val;
    logic [DATA_NOC_W-1:0] noc_out_data;
    logic                  noc_out_rdy;
    logic                  log_wr_req_val;
    tracker_rec_struct     log_wr_req_data;
    logic                  log_wr_req_rdy;

    modport master (
        input  noc_in_val, noc_in_data, noc_out_rdy, log_wr_req_rdy,
        output noc_in_rdy, noc_out_val, noc_out_data, log_wr_req_val, log_wr_req_data
    );

    modport slave (
        output noc_in_val, noc_in_data, noc_out_rdy, log_wr_req_rdy,
        input  noc_in_rdy, noc_out_val, noc_out_data, log_wr_req_val, log_wr_req_data
    );

endinterface

// File: rtl/tracker_rec_slot.sv
// One-entry valid/ready record buffer feeding the log sink, with saturating counters
// for records accepted into the slot and records discarded because it was occupied.
module tracker_rec_slot
    import tracker_record_sampler_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rec_val_i,
    input  tracker_rec_struct rec_i,
    output logic              log_val_o,
    output tracker_rec_struct log_data_o,
    input  logic              log_rdy_i,
    output logic [CNT_W-1:0]  rec_cnt_o,
    output logic [CNT_W-1:0]  drop_cnt_o
);

    logic              slotVal_q, slotVal_d;
    tracker_rec_struct slotData_q, slotData_d;
    logic [CNT_W-1:0]  recCnt_q, recCnt_d;
    logic [CNT_W-1:0]  dropCnt_q, dropCnt_d;
    logic              canLoad;

    // A draining slot can be refilled in the same cycle, so back-to-back records never drop.
    assign canLoad = !slotVal_q || log_rdy_i;

    always_comb begin
        slotVal_d  = slotVal_q;
        slotData_d = slotData_q;
        recCnt_d   = recCnt_q;
        dropCnt_d  = dropCnt_q;
        if (rec_val_i && canLoad) begin
            slotVal_d  = 1'b1;
            slotData_d = rec_i;
            if (recCnt_q != '1) begin
                recCnt_d = recCnt_q + 1'b1;
            end
        end else begin
            if (slotVal_q && log_rdy_i) begin
                slotVal_d = 1'b0;
            end
            if (rec_val_i && (dropCnt_q != '1)) begin
                dropCnt_d = dropCnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slotVal_q <= 1'b0;
            recCnt_q  <= '0;
            dropCnt_q <= '0;
        end else begin
            slotVal_q <= slotVal_d;
            recCnt_q  <= recCnt_d;
            dropCnt_q <= dropCnt_d;
        end
    end

    // Payload is only meaningful while slotVal_q is set, so it carries no reset.
    always_ff @(posedge clk) begin
        slotData_q <= slotData_d;
    end

    assign log_val_o  = slotVal_q;
    assign log_data_o = slotData_q;
    assign rec_cnt_o  = recCnt_q;
    assign drop_cnt_o = dropCnt_q;

endmodule

// File: rtl/tracker_record_sampler.sv
// Inline NoC message tracker: passes the link through untouched, frames messages,
// filters/samples them by packet id and logs one timestamped record per selected message.
module tracker_record_sampler
    import tracker_record_sampler_pkg::*;
#(
    parameter int DATA_NOC_W     = 512,
    parameter int TS_W           = TRACKER_TS_W,
    parameter int CNT_W          = 32,
    parameter int SAMPLE_SHIFT_W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    tracker_record_sampler_if.master  bus,
    input  logic                      cfg_en,
    input  logic [PACKET_ID_W-1:0]    cfg_filter_id,
    input  logic [PACKET_ID_W-1:0]    cfg_filter_mask,
    input  logic [SAMPLE_SHIFT_W-1:0] cfg_sample_shift,
    output logic [CNT_W-1:0]          rec_cnt,
    output logic [CNT_W-1:0]          drop_cnt
);

    localparam int SAMPLE_CNT_W = SAMPLE_SHIFT_W + 1;
    localparam int HDR_BASE     = DATA_NOC_W - NOC_HDR_W;

    tracker_rec_state_e          state_q, state_d;
    logic [TS_W-1:0]             ts_q;
    logic [MSG_LENGTH_WIDTH-1:0] flitCnt_q, flitCnt_d;
    logic [PACKET_ID_W-1:0]      pktId_q, pktId_d;
    logic [MSG_LENGTH_WIDTH-1:0] msgLen_q, msgLen_d;
    logic [TS_W-1:0]             startTs_q, startTs_d;
    logic                        sel_q, sel_d;
    logic [SAMPLE_CNT_W-1:0]     sampleCnt_q, sampleCnt_d;

    logic                        beat;
    logic [PACKET_ID_W-1:0]      hdrPktId;
    logic [MSG_LENGTH_WIDTH-1:0] hdrMsgLen;
    logic                        match;
    logic [SAMPLE_CNT_W-1:0]     sampleMask;
    logic                        selNow;
    logic                        msgDone;
    logic [PACKET_ID_W-1:0]      recPktId;
    logic [MSG_LENGTH_WIDTH-1:0] recMsgLen;
    logic [TS_W-1:0]             recStartTs;
    logic                        recSel;
    logic [TS_W-1:0]             recDuration;
    logic                        recVal;
    tracker_rec_struct           rec;

    // Tracking only observes the link; it never gates valid, ready or data.
    assign bus.noc_out_val  = bus.noc_in_val;
    assign bus.noc_out_data = bus.noc_in_data;
    assign bus.noc_in_rdy   = bus.noc_out_rdy;

    assign beat      = bus.noc_in_val && bus.noc_out_rdy;
    assign hdrPktId  = bus.noc_in_data[HDR_BASE + HDR_PKT_ID_LSB +: PACKET_ID_W];
    assign hdrMsgLen = bus.noc_in_data[HDR_BASE + HDR_MSG_LEN_LSB +: MSG_LENGTH_WIDTH];

    // Shifts wider than the sample counter saturate the mask to the counter's full range.
    assign match      = cfg_en && (((hdrPktId ^ cfg_filter_id) & cfg_filter_mask) == '0);
    assign sampleMask = SAMPLE_CNT_W'(low_ones(32'(cfg_sample_shift)));
    assign selNow     = match && ((sampleCnt_q & sampleMask) == '0);

    always_comb begin
        state_d     = state_q;
        flitCnt_d   = flitCnt_q;
        pktId_d     = pktId_q;
        msgLen_d    = msgLen_q;
        startTs_d   = startTs_q;
        sel_d       = sel_q;
        sampleCnt_d = sampleCnt_q;
        msgDone     = 1'b0;
        recPktId    = pktId_q;
        recMsgLen   = msgLen_q;
        recStartTs  = startTs_q;
        recSel      = sel_q;
        case (state_q)
            HDR: begin
                if (beat) begin
                    pktId_d   = hdrPktId;
                    msgLen_d  = hdrMsgLen;
                    startTs_d = ts_q;
                    sel_d     = selNow;
                    flitCnt_d = '0;
                    if (match) begin
                        sampleCnt_d = sampleCnt_q + 1'b1;
                    end
                    // Header-only messages complete on the header beat itself.
                    if (hdrMsgLen == '0) begin
                        msgDone    = 1'b1;
                        recPktId   = hdrPktId;
                        recMsgLen  = hdrMsgLen;
                        recStartTs = ts_q;
                        recSel     = selNow;
                    end else begin
                        state_d = BODY;
                    end
                end
            end
            BODY: begin
                if (beat) begin
                    flitCnt_d = flitCnt_q + 1'b1;
                    if (flitCnt_d == msgLen_q) begin
                        msgDone = 1'b1;
                        state_d = HDR;
                    end
                end
            end
            default: begin
                state_d = HDR;
            end
        endcase
    end

    assign recDuration      = ts_q - recStartTs;
    assign recVal           = msgDone && recSel;
    assign rec.packet_id    = recPktId;
    assign rec.msg_len      = recMsgLen;
    assign rec.start_ts     = TRACKER_TS_W'(recStartTs);
    assign rec.end_ts       = TRACKER_TS_W'(ts_q);
    assign rec.duration     = TRACKER_TS_W'(recDuration);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HDR;
            ts_q        <= '0;
            flitCnt_q   <= '0;
            pktId_q     <= '0;
            msgLen_q    <= '0;
            startTs_q   <= '0;
            sel_q       <= 1'b0;
            sampleCnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ts_q        <= ts_q + 1'b1;
            flitCnt_q   <= flitCnt_d;
            pktId_q     <= pktId_d;
            msgLen_q    <= msgLen_d;
            startTs_q   <= startTs_d;
            sel_q       <= sel_d;
            sampleCnt_q <= sampleCnt_d;
        end
    end

    tracker_rec_slot #(
        .CNT_W (CNT_W)
    ) u_slot (
        .clk        (clk),
        .rst        (rst),
        .rec_val_i  (recVal),
        .rec_i      (rec),
        .log_val_o  (bus.log_wr_req_val),
        .log_data_o (bus.log_wr_req_data),
        .log_rdy_i  (bus.log_wr_req_rdy),
        .rec_cnt_o  (rec_cnt),
        .drop_cnt_o (drop_cnt)
    );

endmodule

// File: tb/tb_tracker_record_sampler.sv
// Bench for tracker_record_sampler: directed scenarios with literal record expectations,
// then randomized traffic checked every cycle against a message-level reference model.
module tb_tracker_record_sampler;
    import tracker_record_sampler_pkg::*;

    localparam int DW   = 64;
    localparam int TSW  = 8;
    localparam int CW   = 4;
    localparam int SSW  = 4;
    localparam int TSMOD   = 1 << TSW;
    localparam int CNT_MAX = (1 << CW) - 1;
    localparam int SCNT_MOD = 1 << (SSW + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tracker_record_sampler_if #(.DATA_NOC_W(DW)) bus ();

    logic                   cfg_en;
    logic [PACKET_ID_W-1:0] cfg_filter_id;
    logic [PACKET_ID_W-1:0] cfg_filter_mask;
    logic [SSW-1:0]         cfg_sample_shift;
    logic [CW-1:0]          rec_cnt;
    logic [CW-1:0]          drop_cnt;

    tracker_record_sampler #(
        .DATA_NOC_W     (DW),
        .TS_W           (TSW),
        .CNT_W          (CW),
        .SAMPLE_SHIFT_W (SSW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .cfg_en           (cfg_en),
        .cfg_filter_id    (cfg_filter_id),
        .cfg_filter_mask  (cfg_filter_mask),
        .cfg_sample_shift (cfg_sample_shift),
        .rec_cnt          (rec_cnt),
        .drop_cnt         (drop_cnt)
    );

    int checks = 0;
    int passes = 0;

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: message-level view of framing, selection and the one-deep log slot.
    bit                mInMsg;
    int                mRemain;
    tracker_rec_struct mCur;
    bit                mCurSel;
    int                mMatchCnt;
    bit                mSlotFull;
    tracker_rec_struct mSlot;
    int                mRec;
    int                mDrop;
    int                mTs;
    tracker_rec_struct capQ[$];

    function automatic void modelReset();
        mInMsg = 0; mRemain = 0; mCurSel = 0; mMatchCnt = 0;
        mSlotFull = 0; mRec = 0; mDrop = 0; mTs = 0;
    endfunction

    function automatic void modelStep();
        bit                  beat;
        bit                  done;
        bit                  match;
        int                  period;
        int                  sh;
        beehive_noc_hdr_flit h;
        tracker_rec_struct   r;
        beat = bus.noc_in_val && bus.noc_out_rdy;
        done = 0;
        h = bus.noc_in_data[DW-1 -: NOC_HDR_W];
        if (beat) begin
            if (!mInMsg) begin
                match = cfg_en && (((h.packet_id ^ cfg_filter_id) & cfg_filter_mask) == 0);
                sh = (int'(cfg_sample_shift) > SSW + 1) ? SSW + 1 : int'(cfg_sample_shift);
                period = 1 << sh;
                mCurSel = match && ((mMatchCnt % period) == 0);
                if (match) mMatchCnt = (mMatchCnt + 1) % SCNT_MOD;
                mCur = '0;
                mCur.packet_id = h.packet_id;
                mCur.msg_len = h.msg_len;
                mCur.start_ts = 64'(mTs);
                if (h.msg_len == 0) done = 1;
                else begin
                    mInMsg = 1;
                    mRemain = int'(h.msg_len);
                end
            end else begin
                mRemain--;
                if (mRemain == 0) begin
                    done = 1;
                    mInMsg = 0;
                end
            end
        end
        if (done && mCurSel) begin
            r = mCur;
            r.end_ts = 64'(mTs);
            r.duration = 64'((mTs + TSMOD - int'(mCur.start_ts)) % TSMOD);
            if (!mSlotFull || bus.log_wr_req_rdy) begin
                mSlot = r;
                mSlotFull = 1;
                if (mRec < CNT_MAX) mRec++;
            end else if (mDrop < CNT_MAX) mDrop++;
        end else if (mSlotFull && bus.log_wr_req_rdy) begin
            mSlotFull = 0;
        end
        mTs = (mTs + 1) % TSMOD;
    endfunction

    // Single compare process: checks registered and pass-through outputs, then advances the model.
    always @(negedge clk) begin
        if (rst) begin
            modelReset();
        end else begin
            checkOutput("noc_out_val", bus.noc_out_val, bus.noc_in_val);
            checkOutput("noc_out_data", bus.noc_out_data, bus.noc_in_data);
            checkOutput("noc_in_rdy", bus.noc_in_rdy, bus.noc_out_rdy);
            checkOutput("log_val", bus.log_wr_req_val, mSlotFull);
            if (mSlotFull) checkOutput("log_data", bus.log_wr_req_data, mSlot);
            checkOutput("rec_cnt", rec_cnt, mRec);
            checkOutput("drop_cnt", drop_cnt, mDrop);
            if (bus.log_wr_req_val && bus.log_wr_req_rdy) capQ.push_back(bus.log_wr_req_data);
            modelStep();
        end
    end

    function automatic logic [DW-1:0] rnd();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [DW-1:0] mkHdr(input int id, input int len);
        beehive_noc_hdr_flit h;
        logic [DW-1:0]       f;
        h = '0;
        h.dst_x = XY_W'($urandom);
        h.dst_y = XY_W'($urandom);
        h.msg_type = MSG_TYPE_W'($urandom);
        h.packet_id = PACKET_ID_W'(id);
        h.msg_len = MSG_LENGTH_WIDTH'(len);
        f = rnd();
        f[DW-1 -: NOC_HDR_W] = h;
        return f;
    endfunction

    task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic ordy, input logic lrdy);
        bus.noc_in_val = v;
        bus.noc_in_data = d;
        bus.noc_out_rdy = ordy;
        bus.log_wr_req_rdy = lrdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic lrdy);
        repeat (n) applyStimulus(1'b0, rnd(), 1'b1, lrdy);
    endtask

    task automatic doReset();
        rst = 1'b1;
        idle(2, 1'b1);
        rst = 1'b0;
        capQ.delete();
    endtask

    task automatic sendMsg(input int id, input int len, input logic lrdy);
        applyStimulus(1'b1, mkHdr(id, len), 1'b1, lrdy);
        repeat (len) applyStimulus(1'b1, rnd(), 1'b1, lrdy);
    endtask

    task automatic checkRec(input string name, input int idx, input int id, input int len,
                            input int st, input int en, input int dur);
        if (capQ.size() > idx) begin
            checkOutput({name, ".packet_id"}, capQ[idx].packet_id, id);
            checkOutput({name, ".msg_len"}, capQ[idx].msg_len, len);
            checkOutput({name, ".start_ts"}, capQ[idx].start_ts, st);
            checkOutput({name, ".end_ts"}, capQ[idx].end_ts, en);
            checkOutput({name, ".duration"}, capQ[idx].duration, dur);
        end else begin
            checkOutput({name, ".present"}, capQ.size(), idx + 1);
        end
    endtask

    task automatic setCfg(input logic en, input int id, input int mask, input int shift);
        cfg_en = en;
        cfg_filter_id = PACKET_ID_W'(id);
        cfg_filter_mask = PACKET_ID_W'(mask);
        cfg_sample_shift = SSW'(shift);
    endtask

    task automatic randomizeCfg();
        int r;
        r = $urandom_range(0, 9);
        setCfg(($urandom % 8) != 0, $urandom_range(0, 15), (r < 3) ? 0 : $urandom_range(0, 15),
               (r == 9) ? $urandom_range(4, 15) : $urandom_range(0, 3));
    endtask

    task automatic sendFlitRandom(input logic [DW-1:0] d);
        logic v;
        while ($urandom % 4 == 0) begin
            v = 1'($urandom);
            applyStimulus(v, d, v ? 1'b0 : 1'($urandom), ($urandom % 10) < 7);
        end
        if ($urandom % 10 == 0) randomizeCfg();
        applyStimulus(1'b1, d, 1'b1, ($urandom % 10) < 7);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.noc_in_val = 1'b0;
        bus.noc_in_data = '0;
        bus.noc_out_rdy = 1'b1;
        bus.log_wr_req_rdy = 1'b1;
        setCfg(1'b1, 0, 0, 0);

        $display("[TB] scenario 1: 3-body message starting at ts 10");
        doReset();
        checkOutput("reset.log_val", bus.log_wr_req_val, 0);
        checkOutput("reset.rec_cnt", rec_cnt, 0);
        checkOutput("reset.drop_cnt", drop_cnt, 0);
        idle(10, 1'b1);
        sendMsg(5, 3, 1'b1);
        idle(2, 1'b1);
        checkOutput("s1.count", capQ.size(), 1);
        checkRec("s1.rec0", 0, 5, 3, 10, 13, 3);
        checkOutput("s1.rec_cnt", rec_cnt, 1);

        $display("[TB] scenario 2: header-only then back-to-back message");
        doReset();
        idle(20, 1'b1);
        sendMsg(9, 0, 1'b1);
        sendMsg(6, 1, 1'b1);
        idle(2, 1'b1);
        checkOutput("s2.count", capQ.size(), 2);
        checkRec("s2.rec0", 0, 9, 0, 20, 20, 0);
        checkRec("s2.rec1", 1, 6, 1, 21, 22, 1);

        $display("[TB] scenario 3: id filter 0x4 mask 0xC");
        setCfg(1'b1, 4, 12, 0);
        doReset();
        sendMsg(4, 0, 1'b1);
        sendMsg(8, 0, 1'b1);
        sendMsg(7, 0, 1'b1);
        idle(2, 1'b1);
        checkOutput("s3.count", capQ.size(), 2);
        checkRec("s3.rec0", 0, 4, 0, 0, 0, 0);
        checkRec("s3.rec1", 1, 7, 0, 2, 2, 0);
        checkOutput("s3.rec_cnt", rec_cnt, 2);

        $display("[TB] scenario 4: 1-in-4 sampling");
        setCfg(1'b1, 0, 0, 2);
        doReset();
        for (int i = 1; i <= 8; i++) sendMsg(i, 0, 1'b1);
        idle(2, 1'b1);
        checkOutput("s4.count", capQ.size(), 2);
        checkRec("s4.rec0", 0, 1, 0, 0, 0, 0);
        checkRec("s4.rec1", 1, 5, 0, 4, 4, 0);

        $display("[TB] scenario 5: blocked sink drops, refill while draining");
        setCfg(1'b1, 0, 0, 0);
        doReset();
        sendMsg(1, 0, 1'b0);
        sendMsg(2, 0, 1'b0);
        sendMsg(3, 0, 1'b0);
        idle(1, 1'b0);
        checkOutput("s5.drop_cnt", drop_cnt, 2);
        checkOutput("s5.held_val", bus.log_wr_req_val, 1);
        checkOutput("s5.held_id", bus.log_wr_req_data.packet_id, 1);
        sendMsg(4, 0, 1'b1);
        idle(2, 1'b1);
        checkOutput("s5.count", capQ.size(), 2);
        checkRec("s5.rec0", 0, 1, 0, 0, 0, 0);
        checkRec("s5.rec1", 1, 4, 0, 4, 4, 0);
        checkOutput("s5.drop_final", drop_cnt, 2);
        checkOutput("s5.rec_cnt", rec_cnt, 2);

        $display("[TB] scenario 6: downstream stall mid-body, then reset mid-body");
        doReset();
        applyStimulus(1'b1, mkHdr(3, 2), 1'b1, 1'b1);
        applyStimulus(1'b1, rnd(), 1'b1, 1'b1);
        repeat (5) applyStimulus(1'b1, rnd(), 1'b0, 1'b1);
        applyStimulus(1'b1, rnd(), 1'b1, 1'b1);
        idle(2, 1'b1);
        checkOutput("s6.count", capQ.size(), 1);
        checkRec("s6.rec0", 0, 3, 2, 0, 7, 7);
        sendMsg(10, 0, 1'b0);
        applyStimulus(1'b1, mkHdr(7, 4), 1'b1, 1'b0);
        applyStimulus(1'b1, rnd(), 1'b1, 1'b0);
        checkOutput("s6.pre_rst_val", bus.log_wr_req_val, 1);
        checkOutput("s6.pre_rst_rec_cnt", rec_cnt, 2);
        rst = 1'b1;
        #2;
        checkOutput("s6.rst_val", bus.log_wr_req_val, 0);
        checkOutput("s6.rst_rec_cnt", rec_cnt, 0);
        checkOutput("s6.rst_drop_cnt", drop_cnt, 0);
        applyStimulus(1'b0, rnd(), 1'b1, 1'b1);
        rst = 1'b0;
        capQ.delete();
        sendMsg(8, 0, 1'b1);
        idle(2, 1'b1);
        checkOutput("s6.after_count", capQ.size(), 1);
        checkRec("s6.after_rec", 0, 8, 0, 0, 0, 0);

        $display("[TB] randomized traffic");
        randomizeCfg();
        doReset();
        for (int m = 0; m < 450; m++) begin
            int len;
            if ($urandom % 3 == 0) randomizeCfg();
            len = $urandom_range(0, 4);
            sendFlitRandom(mkHdr($urandom_range(0, 15), len));
            for (int b = 0; b < len; b++) sendFlitRandom(rnd());
        end
        idle(4, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
